sequence_output_collect: RTL

Receive-side companion to the sequence sorter pipeline. It takes the serial, biased, sorted word stream from the last comparator stage and removes the offset bias. It packs each N-word frame into one parallel word, optionally checks that the frame is non-decreasing, and presents the frame downstream with a valid/ready handshake and a one-frame holding buffer.

---
 rtl/sequence_output_collect.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sequence_output_collect.sv
// Unbiases the sorter's serial word stream and packs each N-word frame into one word behind a one-frame valid/ready buffer.
// Optional order check under SEQ_COLLECT_ORDER_CHECK_EN; the frame appears one cycle after its last word, and a full buffer drops new frames (sticky overflow).
module sequence_output_collect #(
  parameter int DW = 8,
  parameter int N  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic [DW-1:0]   inp,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_data,
  output logic            sort_err,
  output logic            frame_err,
  output logic            overflow
);

  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, lane;
  logic [N*DW-1:0] asm_q, asm_d;
  logic [DW-1:0]   unb;
  logic            take, start, done, load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: if (done)  state_d = IDLE;
    endcase
  end

  always_comb begin
    take  = 1'b0;
    start = 1'b0;
    done  = 1'b0;
    case (state_q)
      IDLE: begin
        start = in_valid && in_sof;
        take  = start;
      end
      COLLECT: begin
        take  = in_valid;
        start = in_valid && in_sof;
        done  = in_valid && !in_sof && (idx_q == IW'(N - 1));
      end
    endcase
  end

  // A start-of-frame always lands in lane 0, even mid-frame.
  assign lane = start ? '0 : idx_q;
  assign unb  = {~inp[DW-1], inp[DW-2:0]};
  assign load = done && (!out_valid || out_ready);

  always_comb begin
    idx_d = idx_q;
    if (start)     idx_d = IW'(1);
    else if (done) idx_d = '0;
    else if (take) idx_d = idx_q + 1'b1;
  end

  always_comb begin
    asm_d = asm_q;
    for (int k = 0; k < N; k++) begin
      if (take && lane == IW'(k)) asm_d[k*DW +: DW] = unb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      asm_q     <= '0;
      frame_err <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      frame_err <= (state_q == COLLECT) && in_valid && in_sof;
      if (done) begin
        if (load) begin
          out_valid <= 1'b1;
          out_data  <= asm_d;
        end else begin
          overflow  <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SEQ_COLLECT_ORDER_CHECK_EN
  logic [DW-1:0] prev_q;
  logic          err_q, err_d;

  // Biased unsigned order matches unbiased signed order, so compare raw inputs.
  assign err_d = start ? 1'b0 : (err_q || (inp < prev_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '0;
      err_q    <= 1'b0;
      sort_err <= 1'b0;
    end else begin
      if (take) begin
        prev_q <= inp;
        err_q  <= err_d;
      end
      if (load) sort_err <= err_d;
    end
  end
`else
  assign sort_err = 1'b0;
`endif

endmodule
